// File: rtl/pcie_axi_ram_slave_if.sv
// pcie_axi_ram_slave_if: AXI4 read/write channel bundle between the PCIe AXI master and the RAM slave
interface pcie_axi_ram_slave_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8
);
  logic [ID_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input awready,
    output wdata, wstrb, wlast, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input rready
  );
endinterface

// File: rtl/pcie_axi_ram_slave.sv
// pcie_axi_ram_slave: AXI4 RAM endpoint with independent write and read burst engines
module pcie_axi_ram_slave #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input logic clk,
  input logic rst,
  pcie_axi_ram_slave_if.slave s
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int IW = MEM_ADDR_WIDTH - LSB;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live;
  logic [DATA_WIDTH-1:0] mem [2**IW];
  logic [ID_WIDTH-1:0] w_id, r_id;
  logic [IW-1:0] w_idx, r_idx;
  logic w_inc, r_inc;
  logic [7:0] w_cnt;
  logic [8:0] iss_left;
  logic [DATA_WIDTH-1:0] p_data, r_data;
  logic p_v, p_last, r_v, r_last;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, iss, mv;
  logic unused;
  assign unused = ^{s.awaddr, s.araddr, s.awsize, s.arsize, s.awlock, s.arlock,
                    s.awcache, s.arcache, s.awprot, s.arprot};
  always_comb begin
    aw_hs = s.awvalid && s.awready;
    w_hs = s.wvalid && s.wready;
    b_hs = s.bvalid && s.bready;
    ar_hs = s.arvalid && s.arready;
    r_hs = r_v && s.rready;
    mv = p_v && (!r_v || s.rready);
    iss = iss_left != 9'd0 && (!p_v || mv);
  end
  always_ff @(posedge clk) begin
    w_state <= rst ? W_IDLE : w_next;
    r_state <= rst ? R_IDLE : r_next;
  end
  always_comb begin
    w_next = aw_hs ? W_DATA : (w_hs && (s.wlast || w_cnt == 8'd0)) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_next = ar_hs ? R_DATA : (r_hs && r_last) ? R_IDLE : r_state;
  end
  // live keeps the address channels closed while rst is still held
  always_comb begin
    s.awready = live && w_state == W_IDLE;
    s.wready = w_state == W_DATA;
    s.bvalid = w_state == W_RESP;
    s.bid = w_id;
    s.bresp = 2'b00;
    s.arready = live && r_state == R_IDLE;
    s.rvalid = r_v;
    s.rdata = r_data;
    s.rid = r_id;
    s.rresp = 2'b00;
    s.rlast = r_v && r_last;
  end
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_id <= s.awid;
      w_idx <= s.awaddr[MEM_ADDR_WIDTH-1:LSB];
      w_inc <= s.awburst != 2'd0;
      w_cnt <= s.awlen;
    end else if (w_hs) begin
      w_idx <= w_idx + IW'(w_inc);
      w_cnt <= w_cnt - 8'd1;
    end
    if (ar_hs) begin
      r_id <= s.arid;
      r_idx <= s.araddr[MEM_ADDR_WIDTH-1:LSB];
      r_inc <= s.arburst != 2'd0;
    end else if (iss) r_idx <= r_idx + IW'(r_inc);
    if (iss) begin
      p_data <= mem[r_idx];
      p_last <= iss_left == 9'd1;
    end
    if (mv) begin
      r_data <= p_data;
      r_last <= p_last;
    end
  end
  always_ff @(posedge clk)
    if (w_hs && !rst)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (s.wstrb[i]) mem[w_idx][i*8 +: 8] <= s.wdata[i*8 +: 8];
  // two-stage read pipe: RAM output register doubles as the skid slot behind r_data
  always_ff @(posedge clk)
    if (rst) begin
      live <= 1'b0;
      iss_left <= 9'd0;
      p_v <= 1'b0;
      r_v <= 1'b0;
    end else begin
      live <= 1'b1;
      iss_left <= ar_hs ? {1'b0, s.arlen} + 9'd1 : iss_left - 9'(iss);
      p_v <= iss || (p_v && !mv);
      r_v <= mv || (r_v && !s.rready);
    end
endmodule

// File: tb/tb_pcie_axi_ram_slave.sv
// tb_pcie_axi_ram_slave: directed and randomized bursts checked against a word-array memory model
module tb_pcie_axi_ram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [255:0] model [128];
  pcie_axi_ram_slave_if bus ();
  pcie_axi_ram_slave dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int widx(input logic [63:0] a, input int b, input int burst);
    return (int'(a[11:5]) + (burst == 0 ? 0 : b)) % 128;
  endfunction

  function automatic void mwrite(input int idx, input logic [255:0] d, input logic [31:0] st);
    for (int i = 0; i < 32; i++) if (st[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
  endfunction

  task automatic do_aw(input logic [63:0] a, input int len, input int burst, input logic [7:0] id);
    int n = 0;
    bus.awaddr = a; bus.awlen = 8'(len); bus.awburst = 2'(burst); bus.awid = id;
    bus.awsize = 3'd5; bus.awvalid = 1'b1;
    while (!bus.awready && n < 50) begin step(); n++; end
    chk("aw_wait", n < 50, 1'b1);
    step();
    bus.awvalid = 1'b0;
  endtask

  task automatic do_wbeat(input logic [63:0] a, input int b, input int burst,
                          input logic [255:0] d, input logic [31:0] st, input logic last);
    int n = 0;
    bus.wdata = d; bus.wstrb = st; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 50) begin step(); n++; end
    chk("w_wait", n < 50, 1'b1);
    mwrite(widx(a, b, burst), d, st);
    step();
  endtask

  task automatic do_b(input logic [7:0] id);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 50) begin step(); n++; end
    chk("b_wait", n < 50, 1'b1);
    chk("bid", bus.bid, id);
    chk("bresp", bus.bresp, 2'b00);
    step();
    bus.bready = 1'b0;
  endtask

  task automatic write_burst(input logic [63:0] a, input int len, input int burst,
                             input logic [7:0] id, input logic rstrb);
    do_aw(a, len, burst, id);
    for (int b = 0; b <= len; b++)
      do_wbeat(a, b, burst, rnd256(), rstrb ? $urandom : 32'hFFFF_FFFF, b == len);
    bus.wvalid = 1'b0;
    do_b(id);
  endtask

  task automatic do_ar(input logic [63:0] a, input int len, input int burst, input logic [7:0] id);
    int n = 0;
    bus.araddr = a; bus.arlen = 8'(len); bus.arburst = 2'(burst); bus.arid = id;
    bus.arsize = 3'd5; bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin step(); n++; end
    chk("ar_wait", n < 50, 1'b1);
    step();
    bus.arvalid = 1'b0;
  endtask

  // mode 0: rready held high, 1: repeating 1,0,0,1, 2: random
  task automatic collect_r(input logic [63:0] a, input int len, input int burst,
                           input logic [7:0] id, input int mode);
    int got = 0;
    int cyc = 0;
    logic [255:0] prev = '0;
    logic stall = 1'b0;
    logic rr;
    while (got <= len && cyc < 400) begin
      rr = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      bus.rready = rr;
      if (bus.rvalid) begin
        if (stall) chk("r_stable", bus.rdata, prev);
        if (rr) begin
          chk("rdata", bus.rdata, model[widx(a, got, burst)]);
          chk("rlast", bus.rlast, got == len);
          chk("rid", bus.rid, id);
          got++;
        end
        prev = bus.rdata;
        stall = !rr;
      end
      step();
      cyc++;
    end
    bus.rready = 1'b0;
    chk("r_beats", got, len + 1);
    chk("r_idle", bus.rvalid, 1'b0);
  endtask

  task automatic read_burst(input logic [63:0] a, input int len, input int burst,
                            input logic [7:0] id, input int mode);
    do_ar(a, len, burst, id);
    collect_r(a, len, burst, id, mode);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int len, burst;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) step();
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_wready", bus.wready, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rlast", bus.rlast, 1'b0);
    chk("rst_bresp", bus.bresp, 2'b00);
    chk("rst_rresp", bus.rresp, 2'b00);
    rst = 1'b0;
    step();
    chk("post_rst_awready", bus.awready, 1'b1);
    chk("post_rst_arready", bus.arready, 1'b1);

    write_burst(64'h0, 127, 1, 8'h01, 1'b0);

    do_aw(64'h40, 0, 1, 8'h11);
    do_wbeat(64'h40, 0, 1, {32{8'hA5}}, 32'hFFFF_FFFF, 1'b1);
    bus.wvalid = 1'b0;
    do_b(8'h11);
    do_ar(64'h40, 0, 1, 8'h22);
    chk("r_lat0", bus.rvalid, 1'b0);
    step();
    chk("r_lat1", bus.rvalid, 1'b0);
    step();
    chk("r_lat2", bus.rvalid, 1'b1);
    chk("rdata_a5", bus.rdata, {32{8'hA5}});
    collect_r(64'h40, 0, 1, 8'h22, 0);

    do_aw(64'h100, 3, 1, 8'h12);
    for (int b = 0; b < 4; b++)
      do_wbeat(64'h100, b, 1, rnd256(), b == 1 ? 32'h0000_000F : 32'hFFFF_FFFF, b == 3);
    bus.wvalid = 1'b0;
    do_b(8'h12);
    read_burst(64'h100, 3, 1, 8'h23, 0);

    write_burst(64'h200, 7, 1, 8'h13, 1'b0);
    read_burst(64'h200, 7, 1, 8'h24, 1);

    do_aw(64'h280, 0, 1, 8'h33);
    do_wbeat(64'h280, 0, 1, rnd256(), 32'hFFFF_FFFF, 1'b1);
    bus.wvalid = 1'b0;
    bus.awaddr = 64'h2A0; bus.awlen = 8'd0; bus.awburst = 2'd1; bus.awid = 8'h44; bus.awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bvalid_hold", bus.bvalid, 1'b1);
      chk("aw_blocked", bus.awready, 1'b0);
      step();
    end
    do_b(8'h33);
    chk("aw_after_b", bus.awready, 1'b1);
    step();
    bus.awvalid = 1'b0;
    do_wbeat(64'h2A0, 0, 1, rnd256(), 32'hFFFF_FFFF, 1'b1);
    bus.wvalid = 1'b0;
    do_b(8'h44);
    read_burst(64'h280, 1, 1, 8'h25, 0);

    write_burst(64'hFE0, 3, 1, 8'h55, 1'b0);
    read_burst(64'hFE0, 3, 1, 8'h26, 0);
    read_burst(64'h0, 2, 1, 8'h27, 0);

    for (int k = 0; k < 8; k++) begin
      a = {32'($urandom), 20'($urandom), 7'($urandom), 5'b0};
      len = $urandom_range(0, 7);
      burst = $urandom_range(0, 2);
      write_burst(a, len, burst, 8'($urandom), 1'b1);
      read_burst(a, len, burst, 8'($urandom), 2);
    end

    do_aw(64'h400, 15, 1, 8'h66);
    for (int b = 0; b < 5; b++) do_wbeat(64'h400, b, 1, rnd256(), 32'hFFFF_FFFF, 1'b0);
    bus.wvalid = 1'b0;
    rst = 1'b1;
    step();
    chk("abort_awready", bus.awready, 1'b0);
    chk("abort_wready", bus.wready, 1'b0);
    chk("abort_bvalid", bus.bvalid, 1'b0);
    chk("abort_arready", bus.arready, 1'b0);
    chk("abort_rvalid", bus.rvalid, 1'b0);
    rst = 1'b0;
    step();
    chk("abort_bvalid_after", bus.bvalid, 1'b0);
    write_burst(64'h600, 0, 1, 8'h77, 1'b0);
    read_burst(64'h600, 0, 1, 8'h78, 0);
    read_burst(64'h400, 15, 1, 8'h79, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
